// File: rtl/fft_fixed_pkg.sv
// Shared fixed-point constants and FSM state type for the FFT datapath.
// Used by the multiplier, butterfly and divider blocks.
package fft_fixed_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = WIDTH / 2;

  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division step: shift in a numerator bit, trial subtract.
// Produces the next partial remainder and one quotient bit.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             num_bit,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial = {rem, num_bit};
    diff  = trial - {1'b0, dsr};
    q_bit = (trial >= {1'b0, dsr});
    rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Iterative signed Q-format divider, one quotient bit per cycle.
// Sign/magnitude restoring division with saturation on the way out.
module fixed_point_divider #(
  parameter int WIDTH = fft_fixed_pkg::WIDTH,
  parameter int FRAC  = fft_fixed_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);
  import fft_fixed_pkg::*;

  localparam int NW = WIDTH + FRAC;
  localparam int CW = $clog2(NW);
  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NW-1:0] POS_LIM = NW'(QMAX);
  localparam logic [NW-1:0] NEG_LIM = NW'(QMIN);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   num;
  logic [NW-1:0]   qm;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic            neg;
  logic            dz;
  logic            dvd_zero;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] res_q;
  logic             res_ov;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .num_bit  (num[NW-1]),
    .dsr      (dsr),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct as unsigned
  always_comb begin
    dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_abs = divisor[WIDTH-1] ? -divisor : divisor;
  end

  always_comb begin
    res_q  = '0;
    res_ov = 1'b0;
    if (dz) begin
      res_q = dvd_zero ? '0 : (neg ? QMIN : QMAX);
    end else if (!neg) begin
      if (qm > POS_LIM) begin
        res_q  = QMAX;
        res_ov = 1'b1;
      end else begin
        res_q = qm[WIDTH-1:0];
      end
    end else begin
      if (qm > NEG_LIM) begin
        res_q  = QMIN;
        res_ov = 1'b1;
      end else begin
        res_q = -qm[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      num         <= '0;
      qm          <= '0;
      rem         <= '0;
      dsr         <= '0;
      neg         <= 1'b0;
      dz          <= 1'b0;
      dvd_zero    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            neg         <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dsr         <= dsr_abs;
            num         <= NW'(dvd_abs) << FRAC;
            rem         <= '0;
            qm          <= '0;
            dz          <= (divisor == '0);
            dvd_zero    <= (dividend == '0);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b0;
            cnt         <= CW'(NW - 1);
            state       <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          rem <= rem_nx;
          num <= num << 1;
          qm  <= {qm[NW-2:0], q_bit};
          if (cnt == '0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE: begin
          // first DONE cycle forms the saturated result
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= res_q;
            overflow    <= res_ov;
            div_by_zero <= dz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomized and directed bench for fixed_point_divider.
// Reference is plain integer division with truncation and saturation.
module tb_fixed_point_divider;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int NW = W + F;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  quotient;
  logic          overflow;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  fixed_point_divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output logic [W-1:0] q,
                                output logic ov, output logic dz);
    longint r;
    ov = 1'b0;
    dz = 1'b0;
    q  = '0;
    if (b == 0) begin
      dz = 1'b1;
      if (a > 0) q = 16'h7FFF;
      else if (a < 0) q = 16'h8000;
    end else begin
      r = (longint'(a) * (longint'(1) << F)) / longint'(b);
      if (r > 32767) begin
        q = 16'h7FFF;
        ov = 1'b1;
      end else if (r < -32768) begin
        q = 16'h8000;
        ov = 1'b1;
      end else begin
        q = W'(r);
      end
    end
  endfunction

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic hold_rdy, input string tag);
    logic [W-1:0] eq;
    logic eov, edz;
    int lat;
    model(int'($signed(a)), int'($signed(b)), eq, eov, edz);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    out_ready = 1'b0;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!in_ready) chk({tag, "_in_ready"}, 0, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    out_ready = hold_rdy;
    wait_valid(tag, lat);
    chk({tag, "_lat"}, lat, edz ? 1 : NW + 1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_ov"}, overflow, eov);
    chk({tag, "_dz"}, div_by_zero, edz);
    if (!hold_rdy) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ack"}, out_valid, 0);
  endtask

  logic [W-1:0] specials [8] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0100,
                                 16'hFF00, 16'h0001, 16'hFFFF, 16'h0080};

  initial begin
    int lat;
    logic ok;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_flags", {overflow, div_by_zero}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(16'h0200, 16'h0080, 1'b0, "d_2_over_half");
    run(16'hFD00, 16'h0200, 1'b0, "d_m3_over_2");
    run(16'h0100, 16'h0300, 1'b1, "d_1_over_3");
    run(16'hFF00, 16'h0300, 1'b0, "d_m1_over_3");
    run(16'h6400, 16'h0001, 1'b0, "ov_pos");
    run(16'h8000, 16'hFF00, 1'b1, "ov_min_m1");
    run(16'h8000, 16'h0100, 1'b0, "min_over_1");
    run(16'h0100, 16'h0000, 1'b0, "dz_pos");
    run(16'hFF00, 16'h0000, 1'b1, "dz_neg");
    run(16'h0000, 16'h0000, 1'b0, "dz_zero");

    // backpressure: result held while a new request waits
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h0100;
    divisor  = 16'h0300;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid("bp", lat);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'h0400;
      divisor  = 16'h0100;
      @(posedge clk);
      #1;
      ok &= out_valid && (quotient == 16'h0055) && !in_ready &&
            !overflow && !div_by_zero;
    end
    chk("bp_hold", ok, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_ack_valid", out_valid, 0);
    chk("bp_ack_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 0);
    wait_valid("bp2", lat);
    chk("bp2_lat", lat, NW + 1);
    chk("bp2_q", quotient, 16'h0400);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h0300;
    divisor  = 16'h0100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_result", out_valid, 0);
    run(16'h0200, 16'h0080, 1'b0, "post_rst");

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)]
                                       : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)]
                                       : W'($urandom);
      if ($urandom_range(0, 1) == 1) rb = W'($signed(rb) >>> $urandom_range(0, 12));
      run(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
